display_source: RTL and testbench
=================================

Name: display_source

Overview:
- Upstream feeder of the 8-digit seven-segment display driver; produces the 32-bit `Leddata` word that the driver scans out.
- Captures the value the CPU emits on its display syscall.
- Maintains run statistics: display event count, optional cycle count.
- A debounced board button steps through display modes; the output word is registered and stable between updates.

Parameters:
- DEB_CYCLES, 1_000_000, number of consecutive stable clk samples before a button level is accepted (10 ms at 100 MHz).
- CNT_W, 32, width of the cycle and event counters; must equal 32.

Ports:
- clk  in  1  system clock, same clock as the CPU and display driver
- rst  in  1  synchronous, active-high reset
- halt  in  1  CPU halted (syscall exit); level
- disp_valid  in  1  single-cycle pulse: CPU executed display syscall this cycle
- disp_data  in  32  value to display, valid when disp_valid=1
- pc  in  32  current CPU program counter
- btn_mode  in  1  raw, bouncing mode button, active-high, asynchronous to clk
- Leddata  out  32  word for display driver
- mode  out  2  current display mode, for board LEDs

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk only.
- Reset values: Leddata=0, mode=0, captured value=0, event count=0, cycle count=0, debouncer stable level=0, debouncer counter=0, sync flops=0.
- Synchroniser: btn_mode passes through 2 flops before the debouncer.
- Debouncer:
  - While the synced level differs from the stable level, a counter increments.
  - When it reaches DEB_CYCLES-1, the stable level updates and the counter clears.
  - Any sample equal to the stable level clears the counter.
  - A 0->1 change of the stable level yields a 1-cycle `press` pulse. No pulse is produced on release.
- Mode FSM: four states.
  - SHOW_SYS (0): captured syscall value
  - SHOW_PC (1): pc
  - SHOW_CYC (2): cycle count
  - SHOW_EVT (3): event count
  - On press, the FSM advances 0->1->2->3->0.
- Capture register: loads disp_data on disp_valid, regardless of halt. It holds otherwise.
- Event counter: +1 on each disp_valid; wraps 0xFFFFFFFF->0.
- Cycle counter (feature only): +1 each cycle while halt=0; holds while halt=1; saturates at 0xFFFFFFFF.
- Output register: Leddata is registered from the mux of the current mode's source. Latency is 1 cycle.
  - disp_valid at edge N: capture updates at N; Leddata shows it at N+1 when mode=0.
  - press at edge N: mode updates at N; Leddata switches at N+1.
- Simultaneous events:
  - rst dominates all.
  - disp_valid and press on the same edge: both take effect; the next Leddata uses the new mode and the new value.
- Reset mid-bounce: the debouncer counter clears and no pulse is emitted.

Optional Feature:
- Macro: DISP_CYCLE_CNT_EN.
- Defined: the cycle counter and SHOW_CYC are present, as above.
- Undefined:
  - No cycle counter is synthesised.
  - The FSM sequence is 0->1->3->0; mode never equals 2.
  - If mode=2 were forced, Leddata=0.

Decomposition:
- Shared package (display_pkg): mode encodings MODE_SYS=2'd0, MODE_PC=2'd1, MODE_CYC=2'd2, MODE_EVT=2'd3; default DEB_CYCLES constant.
- One sub-module: btn_debounce.
  - Ports: clk, rst, btn_raw, press.
  - Contains the synchroniser, counter and edge detector.
  - Parameter: DEB_CYCLES.
- The FSM, counters and output mux live in display_source.

Test Plan (bench uses DEB_CYCLES=4):
- Reset: assert rst 2 cycles with btn_mode=1, disp_valid=1 -> Leddata=0, mode=0 throughout; after release, no spurious press for 5 cycles unless btn_mode is held.
- Capture: mode=0, pulse disp_valid with disp_data=0x1234ABCD -> Leddata=0x1234ABCD exactly 1 cycle after the edge; holds after disp_data changes to 0xFFFFFFFF with disp_valid=0.
- Debounce:
  - toggle btn_mode 1,0,1,0 on consecutive cycles -> mode stays 0.
  - hold 1 for 10 cycles -> mode=1 once; Leddata=pc (0x00003000) the following cycle.
  - release -> no further change.
- Mode wrap: 4 clean presses -> mode sequence 1,2,3,0 with macro defined, or 1,3,0 (3 presses) without it; Leddata matches the selected source each time.
- Counters: 5 disp_valid pulses in mode 3 -> Leddata=5; with macro, run 20 cycles halt=0 then halt=1 for 10 cycles -> cycle count=20 held; preload-check saturation by forcing 0xFFFFFFFE, 3 cycles -> 0xFFFFFFFF.
- Simultaneous: disp_valid (0x00000022) and press on the same edge from mode 3 -> mode=0 and Leddata=0x00000022 at the next cycle; rst asserted mid-run -> all outputs 0 on the following edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display source: mode encodings and debounce default.
// The mode sequence depends on the DISP_CYCLE_CNT_EN build option.
package display_pkg;

  typedef enum logic [1:0] {
    MODE_SYS = 2'd0,
    MODE_PC  = 2'd1,
    MODE_CYC = 2'd2,
    MODE_EVT = 2'd3
  } mode_e;

  // 10 ms at 100 MHz
  localparam int unsigned DEB_CYCLES_DEF = 1_000_000;

  function automatic mode_e next_mode(input mode_e m);
    case (m)
      MODE_SYS: return MODE_PC;
`ifdef DISP_CYCLE_CNT_EN
      MODE_PC:  return MODE_CYC;
`else
      MODE_PC:  return MODE_EVT;
`endif
      MODE_CYC: return MODE_EVT;
      default:  return MODE_SYS;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer for the board mode button.
// Emits a single-cycle press pulse on an accepted 0->1 transition only.
module btn_debounce
  import display_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
        press_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= btn_raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/display_source.sv
// Feeds the 8-digit display driver: syscall capture, event/cycle statistics and a button-driven mode FSM.
// Build option DISP_CYCLE_CNT_EN adds the saturating cycle counter and the SHOW_CYC mode.
//
//   state    | meaning
//   ---------+---------------------------------------
//   MODE_SYS | show last value from display syscall
//   MODE_PC  | show current program counter
//   MODE_CYC | show running cycle count (option only)
//   MODE_EVT | show number of display syscalls
module display_source
  import display_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int          CNT_W      = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        halt,
  input  logic        disp_valid,
  input  logic [31:0] disp_data,
  input  logic [31:0] pc,
  input  logic        btn_mode,
  output logic [31:0] Leddata,
  output logic [1:0]  mode
);

  logic             press;
  mode_e            mode_q;
  logic [31:0]      cap_q, cap_d;
  logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
  logic [31:0]      led_q, led_d;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_mode),
    .press   (press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_SYS;
    end else if (press) begin
      mode_q <= next_mode(mode_q);
    end
  end

`ifdef DISP_CYCLE_CNT_EN
  logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    if (!halt && (cyc_cnt_q != {CNT_W{1'b1}})) begin
      cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
    end
  end
`else
  logic unused_halt;
  assign unused_halt = halt;
`endif

  // Capture ignores halt so the final syscall before exit is still shown.
  always_comb begin
    cap_d     = cap_q;
    evt_cnt_d = evt_cnt_q;
    if (disp_valid) begin
      cap_d     = disp_data;
      evt_cnt_d = evt_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    led_d = '0;
    case (mode_q)
      MODE_SYS: led_d = cap_q;
      MODE_PC:  led_d = pc;
`ifdef DISP_CYCLE_CNT_EN
      MODE_CYC: led_d = cyc_cnt_q;
`else
      MODE_CYC: led_d = '0;
`endif
      MODE_EVT: led_d = evt_cnt_q;
      default:  led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q     <= '0;
      evt_cnt_q <= '0;
      led_q     <= '0;
    end else begin
      cap_q     <= cap_d;
      evt_cnt_q <= evt_cnt_d;
      led_q     <= led_d;
    end
  end

  assign Leddata = led_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_display_source.sv
// Self-checking bench for display_source: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the display source.
module tb_display_source;

  localparam int DEB = 4;
`ifdef DISP_CYCLE_CNT_EN
  localparam bit HAS_CYC = 1'b1;
`else
  localparam bit HAS_CYC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        halt;
  logic        disp_valid;
  logic [31:0] disp_data;
  logic [31:0] pc;
  logic        btn_mode;
  logic [31:0] Leddata;
  logic [1:0]  mode;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  display_source #(.DEB_CYCLES(DEB), .CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .halt       (halt),
    .disp_valid (disp_valid),
    .disp_data  (disp_data),
    .pc         (pc),
    .btn_mode   (btn_mode),
    .Leddata    (Leddata),
    .mode       (mode)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model
  bit          model_on = 1'b0;
  logic [31:0] led_m, cap_m, evt_m, cyc_m;
  int          mode_m;
  bit          stable_m, press_m;
  bit          hist[$];

  function automatic int model_next(input int m);
    if (m == 3) return 0;
    if (m == 1 && !HAS_CYC) return 3;
    return m + 1;
  endfunction

  function automatic logic [31:0] model_src(input int m);
    case (m)
      0: return cap_m;
      1: return pc;
      2: return HAS_CYC ? cyc_m : 32'd0;
      default: return evt_m;
    endcase
  endfunction

  always @(posedge clk) begin : model
    bit flip;
    int last;
    if (rst) begin
      led_m = 0; cap_m = 0; evt_m = 0; cyc_m = 0;
      mode_m = 0; stable_m = 0; press_m = 0;
      hist.delete();
      for (int i = 0; i < DEB + 2; i++) hist.push_back(1'b0);
      model_on = 1'b1;
    end else if (model_on) begin
      led_m = model_src(mode_m);
      if (press_m) mode_m = model_next(mode_m);
      if (disp_valid) begin
        cap_m = disp_data;
        evt_m = evt_m + 1;
      end
      if (HAS_CYC && !halt && cyc_m != 32'hFFFF_FFFF) cyc_m = cyc_m + 1;
      // button level accepted once the last DEB synchronised samples all disagree with it
      last = hist.size() - 1;
      flip = 1'b1;
      for (int i = 0; i < DEB; i++) if (hist[last - 1 - i] == stable_m) flip = 1'b0;
      press_m = 1'b0;
      if (flip) begin
        stable_m = ~stable_m;
        press_m  = stable_m;
      end
      hist.push_back(btn_mode);
      if (hist.size() > 32) void'(hist.pop_front());
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_eq("model_led", Leddata, led_m);
      check_eq("model_mode", {30'd0, mode}, 32'(mode_m));
    end
  end

  task automatic press_btn();
    btn_mode = 1'b1;
    repeat (8) @(negedge clk);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int seq[$];
    int run;
    bit seen;

    rst = 1'b1; halt = 1'b0; disp_valid = 1'b1; disp_data = 32'hDEAD_BEEF;
    pc = 32'h0000_3000; btn_mode = 1'b1;

    // reset held two cycles with noisy inputs
    @(negedge clk);
    check_eq("rst_led0", Leddata, 32'd0);
    check_eq("rst_mode0", {30'd0, mode}, 32'd0);
    @(negedge clk);
    check_eq("rst_led1", Leddata, 32'd0);
    check_eq("rst_mode1", {30'd0, mode}, 32'd0);
    rst = 1'b0; disp_valid = 1'b0; btn_mode = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_spurious", {30'd0, mode}, 32'd0);

    // capture latency and hold
    disp_valid = 1'b1; disp_data = 32'h1234_ABCD;
    @(negedge clk);
    disp_valid = 1'b0; disp_data = 32'hFFFF_FFFF;
    check_eq("cap_not_yet", Leddata, 32'd0);
    @(negedge clk);
    check_eq("cap_show", Leddata, 32'h1234_ABCD);
    repeat (3) @(negedge clk);
    check_eq("cap_hold", Leddata, 32'h1234_ABCD);

    // bounce shorter than the debounce window
    for (int i = 0; i < 4; i++) begin
      btn_mode = (i % 2 == 0);
      @(negedge clk);
    end
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("bounce_mode", {30'd0, mode}, 32'd0);

    // clean hold -> one press
    btn_mode = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("hold_mode", {30'd0, mode}, 32'd1);
    check_eq("hold_pc", Leddata, 32'h0000_3000);
    btn_mode = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("release_mode", {30'd0, mode}, 32'd1);

    // wrap through remaining modes back to 1
    if (HAS_CYC) seq = '{2, 3, 0, 1};
    else         seq = '{3, 0, 1};
    foreach (seq[i]) begin
      press_btn();
      check_eq("wrap_mode", {30'd0, mode}, 32'(seq[i]));
      case (seq[i])
        0: check_eq("wrap_sys", Leddata, 32'h1234_ABCD);
        1: check_eq("wrap_pc", Leddata, 32'h0000_3000);
        3: check_eq("wrap_evt", Leddata, 32'd1);
        default: ;
      endcase
    end

    // counters from a fresh reset
    do_reset();
    halt = 1'b0;
    repeat (20) @(negedge clk);
    halt = 1'b1;
    repeat (10) @(negedge clk);
`ifdef DISP_CYCLE_CNT_EN
    check_eq("cyc_held", dut.cyc_cnt_q, 32'd20);
`endif
    for (int i = 0; i < 4 && mode_m != 3; i++) press_btn();
    check_eq("evt_mode", {30'd0, mode}, 32'd3);
    for (int i = 0; i < 5; i++) begin
      disp_valid = 1'b1; disp_data = $urandom;
      @(negedge clk);
      disp_valid = 1'b0;
      @(negedge clk);
    end
    @(negedge clk);
    check_eq("evt_five", Leddata, 32'd5);

`ifdef DISP_CYCLE_CNT_EN
    halt = 1'b0;
    force dut.cyc_cnt_q = 32'hFFFF_FFFE;
    @(posedge clk);
    #1;
    release dut.cyc_cnt_q;
    cyc_m = 32'hFFFF_FFFE;
    repeat (3) @(negedge clk);
    check_eq("cyc_sat", dut.cyc_cnt_q, 32'hFFFF_FFFF);
    halt = 1'b1;
`endif

    // syscall and press on the same edge, from mode 3
    btn_mode = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (press_m) begin
        seen = 1'b1;
        disp_valid = 1'b1; disp_data = 32'h0000_0022;
        @(negedge clk);
        disp_valid = 1'b0;
        @(negedge clk);
        check_eq("simul_mode", {30'd0, mode}, 32'd0);
        check_eq("simul_led", Leddata, 32'h0000_0022);
      end
    end
    if (!seen) check_eq("simul_timeout", 32'd0, 32'd1);
    btn_mode = 1'b0;
    repeat (10) @(negedge clk);

    // randomized traffic
    run = 0;
    for (int c = 0; c < 600; c++) begin
      if (run == 0) begin
        btn_mode = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 9);
      end
      run--;
      disp_valid = ($urandom_range(0, 3) == 0);
      disp_data  = $urandom;
      halt       = 1'($urandom_range(0, 1));
      pc         = $urandom;
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end

    // reset mid-run
    btn_mode = 1'b1; disp_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_led", Leddata, 32'd0);
    check_eq("rst_mid_mode", {30'd0, mode}, 32'd0);
    rst = 1'b0; disp_valid = 1'b0; btn_mode = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
